// File: rtl/touch_grid_pkg.sv
// Shared geometry, FSM state type and cell coordinate type for the touch grid sampler.
package touch_grid_pkg;

    localparam int unsigned GRID_COLS = 8;
    localparam int unsigned GRID_ROWS = 12;
    localparam int unsigned COORD_W   = 12;

    typedef enum logic [1:0] {
        StIdle,
        StQuant,
        StFilter,
        StCommit
    } state_t;

    typedef struct packed {
        logic [2:0] col;
        logic [3:0] row;
    } cell_t;

    // Bit 7 of a row word is the leftmost column.
    function automatic logic [GRID_COLS-1:0] col_mask(input logic [2:0] col);
        return 8'h80 >> col;
    endfunction

endpackage

// File: rtl/touch_cell_quantizer.sv
// One-axis repeated-subtraction divider: start loads a residue, idx counts whole cells removed.
module touch_cell_quantizer #(
    parameter int unsigned CELL  = 460,
    parameter int unsigned STEPS = 8,
    parameter int unsigned W     = 12,
    parameter int unsigned IDX_W = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     value,
    output logic             done,
    output logic [IDX_W-1:0] idx
);

    localparam logic [W-1:0] CELL_V = W'(CELL);

    logic [W-1:0]     res_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            idx_q <= '0;
        end else if (start) begin
            res_q <= value;
            idx_q <= '0;
        end else if (res_q >= CELL_V) begin
            res_q <= res_q - CELL_V;
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    // Finished as soon as the residue fits inside one cell; no extra settle cycle.
    assign done = (res_q < CELL_V);
    assign idx  = idx_q;

endmodule

// File: rtl/touch_grid_sampler.sv
// Quantizes raw touch samples into an 8x12 ink bitmap with jitter filtering and stroke timing.
// Build macro TOUCH_GRID_THICK_EN also inks the in-grid 4-neighbours of each committed cell.
module touch_grid_sampler
    import touch_grid_pkg::*;
#(
    parameter int unsigned X_MIN      = 200,
    parameter int unsigned Y_MIN      = 200,
    parameter int unsigned CELL_W     = 460,
    parameter int unsigned CELL_H     = 306,
    parameter int unsigned HITS       = 2,
    parameter int unsigned GAP_CYCLES = 10000000
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    input  logic [COORD_W-1:0]   iX_COORD,
    input  logic [COORD_W-1:0]   iY_COORD,
    input  logic                 iNEW_COORD,
    input  logic                 iCLEAR,
    output logic [GRID_COLS-1:0] oARR0,
    output logic [GRID_COLS-1:0] oARR1,
    output logic [GRID_COLS-1:0] oARR2,
    output logic [GRID_COLS-1:0] oARR3,
    output logic [GRID_COLS-1:0] oARR4,
    output logic [GRID_COLS-1:0] oARR5,
    output logic [GRID_COLS-1:0] oARR6,
    output logic [GRID_COLS-1:0] oARR7,
    output logic [GRID_COLS-1:0] oARR8,
    output logic [GRID_COLS-1:0] oARR9,
    output logic [GRID_COLS-1:0] oARR10,
    output logic [GRID_COLS-1:0] oARR11,
    output logic [6:0]           oINK_CNT,
    output logic                 oBUSY,
    output logic                 oPEN,
    output logic                 oDONE
);

    localparam int unsigned HIT_W = $clog2(HITS + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned EXT_W = COORD_W + 1;

    localparam logic [HIT_W-1:0]   HITS_V = HIT_W'(HITS);
    localparam logic [GAP_W-1:0]   GAP_V  = GAP_W'(GAP_CYCLES);
    localparam logic [COORD_W-1:0] X_OFF  = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] Y_OFF  = COORD_W'(Y_MIN);
    localparam logic [EXT_W-1:0]   X_LO   = EXT_W'(X_MIN);
    localparam logic [EXT_W-1:0]   X_HI   = EXT_W'(X_MIN + GRID_COLS * CELL_W);
    localparam logic [EXT_W-1:0]   Y_LO   = EXT_W'(Y_MIN);
    localparam logic [EXT_W-1:0]   Y_HI   = EXT_W'(Y_MIN + GRID_ROWS * CELL_H);

    state_t                                state_q, state_d;
    logic [GRID_ROWS-1:0][GRID_COLS-1:0]   rows_q, rows_d, paint;
    logic [GRID_COLS-1:0]                  center, fresh;
    logic [6:0]                            ink_q, ink_d;
    logic                                  busy_q, pen_q, pen_d, done_q, done_d;
    logic [GAP_W-1:0]                      gap_q, gap_d;
    logic [HIT_W-1:0]                      hit_q, hit_d;
    cell_t                                 last_q, last_d, cur;
    logic                                  last_valid_q, last_valid_d;
    logic                                  in_range, q_start, qx_done, qy_done;

    // 13-bit compares so the upper bounds cannot wrap.
    assign in_range = ({1'b0, iX_COORD} >= X_LO) && ({1'b0, iX_COORD} < X_HI) &&
                      ({1'b0, iY_COORD} >= Y_LO) && ({1'b0, iY_COORD} < Y_HI);

    touch_cell_quantizer #(
        .CELL  (CELL_W),
        .STEPS (GRID_COLS),
        .W     (COORD_W),
        .IDX_W (3)
    ) u_quant_x (
        .clk   (iCLK),
        .rst_n (iRST_n),
        .start (q_start),
        .value (iX_COORD - X_OFF),
        .done  (qx_done),
        .idx   (cur.col)
    );

    touch_cell_quantizer #(
        .CELL  (CELL_H),
        .STEPS (GRID_ROWS),
        .W     (COORD_W),
        .IDX_W (4)
    ) u_quant_y (
        .clk   (iCLK),
        .rst_n (iRST_n),
        .start (q_start),
        .value (iY_COORD - Y_OFF),
        .done  (qy_done),
        .idx   (cur.row)
    );

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        ink_d        = ink_q;
        pen_d        = pen_q;
        done_d       = 1'b0;
        gap_d        = gap_q;
        hit_d        = hit_q;
        last_d       = last_q;
        last_valid_d = last_valid_q;
        q_start      = 1'b0;
        paint        = '0;
        center       = col_mask(cur.col);
        fresh        = '0;

        unique case (state_q)
            StIdle: begin
                if (iNEW_COORD && in_range) begin
                    q_start = 1'b1;
                    state_d = StQuant;
                end
            end
            StQuant: begin
                if (qx_done && qy_done) state_d = StFilter;
            end
            StFilter: begin
                if (last_valid_q && (cur == last_q)) begin
                    hit_d = (hit_q == HITS_V) ? hit_q : hit_q + HIT_W'(1);
                end else begin
                    hit_d        = HIT_W'(1);
                    last_d       = cur;
                    last_valid_d = 1'b1;
                end
                state_d = (hit_d == HITS_V) ? StCommit : StIdle;
            end
            StCommit: begin
`ifdef TOUCH_GRID_THICK_EN
                // Row shifts drop out-of-grid columns instead of wrapping.
                paint[cur.row] = center | (center << 1) | (center >> 1);
                if (cur.row != 4'd0) paint[cur.row - 4'd1] = center;
                if (cur.row != 4'(GRID_ROWS - 1)) paint[cur.row + 4'd1] = center;
`else
                paint[cur.row] = center;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        for (int unsigned r = 0; r < GRID_ROWS; r++) begin
            fresh     = paint[r] & ~rows_q[r];
            rows_d[r] = rows_q[r] | paint[r];
            for (int unsigned c = 0; c < GRID_COLS; c++) begin
                ink_d = ink_d + 7'(fresh[c]);
            end
        end

        // A strobe in any state restarts the stroke gap, so it beats expiry.
        if (iNEW_COORD) begin
            pen_d = 1'b1;
            gap_d = GAP_V;
        end else if (pen_q) begin
            if (gap_q <= GAP_W'(1)) begin
                gap_d        = '0;
                pen_d        = 1'b0;
                hit_d        = '0;
                last_valid_d = 1'b0;
                done_d       = (ink_d != 7'd0);
            end else begin
                gap_d = gap_q - GAP_W'(1);
            end
        end

        if (iCLEAR) begin
            state_d      = StIdle;
            rows_d       = '0;
            ink_d        = '0;
            pen_d        = 1'b0;
            done_d       = 1'b0;
            gap_d        = '0;
            hit_d        = '0;
            last_valid_d = 1'b0;
            q_start      = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= StIdle;
            rows_q       <= '0;
            ink_q        <= '0;
            busy_q       <= 1'b0;
            pen_q        <= 1'b0;
            done_q       <= 1'b0;
            gap_q        <= '0;
            hit_q        <= '0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            ink_q        <= ink_d;
            busy_q       <= (state_d != StIdle);
            pen_q        <= pen_d;
            done_q       <= done_d;
            gap_q        <= gap_d;
            hit_q        <= hit_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign oARR0    = rows_q[0];
    assign oARR1    = rows_q[1];
    assign oARR2    = rows_q[2];
    assign oARR3    = rows_q[3];
    assign oARR4    = rows_q[4];
    assign oARR5    = rows_q[5];
    assign oARR6    = rows_q[6];
    assign oARR7    = rows_q[7];
    assign oARR8    = rows_q[8];
    assign oARR9    = rows_q[9];
    assign oARR10   = rows_q[10];
    assign oARR11   = rows_q[11];
    assign oINK_CNT = ink_q;
    assign oBUSY    = busy_q;
    assign oPEN     = pen_q;
    assign oDONE    = done_q;

endmodule

// File: tb/tb_touch_grid_sampler.sv
// Two sampler instances (HITS=1 and HITS=2, short gap) checked against a division-based grid model.
module tb_touch_grid_sampler;

    localparam int XMIN = 200;
    localparam int YMIN = 200;
    localparam int CW   = 460;
    localparam int CH   = 306;
    localparam int GAP  = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] x = '0;
    logic [11:0] y = '0;
    logic        nc = 1'b0;
    logic        clr = 1'b0;

    logic [11:0][7:0] ga, gb;
    logic [6:0]       cnt_a, cnt_b;
    logic             busy_a, busy_b, pen_a, pen_b, done_a, done_b;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: index 0 mirrors HITS=1, index 1 mirrors HITS=2.
    logic [11:0][7:0] mg [2];
    int               m_cnt [2];
    int               m_hits [2] = '{1, 2};
    int               m_hit [2];
    int               m_col [2];
    int               m_row [2];
    bit               m_lv [2];

    always #5 clk = ~clk;

    touch_grid_sampler #(
        .X_MIN(XMIN), .Y_MIN(YMIN), .CELL_W(CW), .CELL_H(CH), .HITS(1), .GAP_CYCLES(GAP)
    ) dut_a (
        .iCLK(clk), .iRST_n(rst_n), .iX_COORD(x), .iY_COORD(y), .iNEW_COORD(nc), .iCLEAR(clr),
        .oARR0(ga[0]), .oARR1(ga[1]), .oARR2(ga[2]), .oARR3(ga[3]), .oARR4(ga[4]),
        .oARR5(ga[5]), .oARR6(ga[6]), .oARR7(ga[7]), .oARR8(ga[8]), .oARR9(ga[9]),
        .oARR10(ga[10]), .oARR11(ga[11]),
        .oINK_CNT(cnt_a), .oBUSY(busy_a), .oPEN(pen_a), .oDONE(done_a)
    );

    touch_grid_sampler #(
        .X_MIN(XMIN), .Y_MIN(YMIN), .CELL_W(CW), .CELL_H(CH), .HITS(2), .GAP_CYCLES(GAP)
    ) dut_b (
        .iCLK(clk), .iRST_n(rst_n), .iX_COORD(x), .iY_COORD(y), .iNEW_COORD(nc), .iCLEAR(clr),
        .oARR0(gb[0]), .oARR1(gb[1]), .oARR2(gb[2]), .oARR3(gb[3]), .oARR4(gb[4]),
        .oARR5(gb[5]), .oARR6(gb[6]), .oARR7(gb[7]), .oARR8(gb[8]), .oARR9(gb[9]),
        .oARR10(gb[10]), .oARR11(gb[11]),
        .oINK_CNT(cnt_b), .oBUSY(busy_b), .oPEN(pen_b), .oDONE(done_b)
    );

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            mg[m] = '0; m_cnt[m] = 0; m_hit[m] = 0; m_lv[m] = 1'b0;
        end
    endtask

    task automatic model_end_stroke();
        for (int m = 0; m < 2; m++) begin
            m_hit[m] = 0; m_lv[m] = 1'b0;
        end
    endtask

    task automatic model_set(input int m, input int c, input int r);
        if (c >= 0 && c < 8 && r >= 0 && r < 12 && !mg[m][r][7-c]) begin
            mg[m][r][7-c] = 1'b1;
            m_cnt[m]++;
        end
    endtask

    task automatic model_sample(input int sx, input int sy);
        int c, r;
        if (sx < XMIN || sx >= XMIN + 8 * CW || sy < YMIN || sy >= YMIN + 12 * CH) return;
        c = (sx - XMIN) / CW;
        r = (sy - YMIN) / CH;
        for (int m = 0; m < 2; m++) begin
            if (m_lv[m] && m_col[m] == c && m_row[m] == r) begin
                if (m_hit[m] < m_hits[m]) m_hit[m]++;
            end else begin
                m_hit[m] = 1; m_col[m] = c; m_row[m] = r; m_lv[m] = 1'b1;
            end
            if (m_hit[m] == m_hits[m]) begin
                model_set(m, c, r);
`ifdef TOUCH_GRID_THICK_EN
                model_set(m, c - 1, r); model_set(m, c + 1, r);
                model_set(m, c, r - 1); model_set(m, c, r + 1);
`endif
            end
        end
    endtask

    // One strobe, then enough idle cycles for the worst-case pipeline.
    task automatic send(input int sx, input int sy);
        @(negedge clk);
        x = 12'(sx); y = 12'(sy); nc = 1'b1;
        @(negedge clk);
        nc = 1'b0;
        repeat (20) @(negedge clk);
        model_sample(sx, sy);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total += 4;
        if (ga !== '0 || gb !== '0) begin
            n_bad++; $display("FAIL reset_grid: got %h/%h want 0", ga, gb);
        end
        if (cnt_a !== 7'd0 || cnt_b !== 7'd0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0", cnt_a, cnt_b);
        end
        if ({busy_a, busy_b, pen_a, pen_b} !== 4'b0) begin
            n_bad++; $display("FAIL reset_busy_pen: got %b want 0000", {busy_a, busy_b, pen_a, pen_b});
        end
        if (done_a !== 1'b0 || done_b !== 1'b0) begin
            n_bad++; $display("FAIL reset_done: got %b%b want 00", done_a, done_b);
        end
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_single_hit();
        logic [11:0][7:0] exp;
        exp = '0;
        exp[0] = 8'h80;
        do_clear();
        send(200, 200);
        n_total += 3;
        if (ga !== exp || cnt_a !== 7'd1) begin
            n_bad++; $display("FAIL single_hit_a: got %h cnt %0d want %h cnt 1", ga, cnt_a, exp);
        end
        if (gb !== '0 || cnt_b !== 7'd0) begin
            n_bad++; $display("FAIL single_hit_b: got %h cnt %0d want 0", gb, cnt_b);
        end
        if (ga !== mg[0]) begin
            n_bad++; $display("FAIL single_hit_model: got %h want %h", ga, mg[0]);
        end
    endtask

    task automatic test_hits();
        logic [11:0][7:0] exp;
        exp = '0;
        exp[2] = 8'h20;
        do_clear();
        send(1200, 900);
        n_total++;
        if (gb !== '0 || cnt_b !== 7'd0) begin
            n_bad++; $display("FAIL hits_first: got %h cnt %0d want 0", gb, cnt_b);
        end
        send(1200, 900);
        n_total++;
        if (gb !== exp || cnt_b !== 7'd1) begin
            n_bad++; $display("FAIL hits_second: got %h cnt %0d want %h cnt 1", gb, cnt_b, exp);
        end
        send(1200, 900);
        n_total += 2;
        if (gb !== exp || cnt_b !== 7'd1) begin
            n_bad++; $display("FAIL hits_third: got %h cnt %0d want %h cnt 1", gb, cnt_b, exp);
        end
        if (ga !== exp || cnt_a !== 7'd1) begin
            n_bad++; $display("FAIL hits_a: got %h cnt %0d want %h cnt 1", ga, cnt_a, exp);
        end
    endtask

    task automatic test_out_of_range();
        logic [11:0][7:0] exp;
        do_clear();
        send(100, 500);
        send(3880, 500);
        send(500, 3872);
        n_total += 3;
        if (ga !== '0 || gb !== '0) begin
            n_bad++; $display("FAIL oor_grid: got %h/%h want 0", ga, gb);
        end
        if (cnt_a !== 7'd0 || cnt_b !== 7'd0) begin
            n_bad++; $display("FAIL oor_cnt: got %0d/%0d want 0", cnt_a, cnt_b);
        end
        if (pen_a !== 1'b1 || pen_b !== 1'b1) begin
            n_bad++; $display("FAIL oor_pen: got %b%b want 11", pen_a, pen_b);
        end
        exp = '0;
        exp[11] = 8'h01;
        send(3879, 3871);
        n_total++;
        if (ga !== exp || cnt_a !== 7'd1) begin
            n_bad++; $display("FAIL corner_cell: got %h cnt %0d want %h cnt 1", ga, cnt_a, exp);
        end
    endtask

    task automatic test_gap();
        int pulses_a, pulses_b;
        do_clear();
        send(1200, 900);
        send(1200, 900);
        pulses_a = 0; pulses_b = 0;
        repeat (150) begin
            @(negedge clk);
            pulses_a += int'(done_a);
            pulses_b += int'(done_b);
        end
        model_end_stroke();
        n_total += 3;
        if (pulses_a != 1 || pulses_b != 1) begin
            n_bad++; $display("FAIL gap_done: got %0d/%0d pulses want 1/1", pulses_a, pulses_b);
        end
        if (pen_a !== 1'b0 || pen_b !== 1'b0) begin
            n_bad++; $display("FAIL gap_pen: got %b%b want 00", pen_a, pen_b);
        end
        if (gb !== mg[1] || cnt_b !== 7'(m_cnt[1])) begin
            n_bad++; $display("FAIL gap_keep: got %h want %h", gb, mg[1]);
        end
        do_clear();
        send(100, 500);
        pulses_a = 0; pulses_b = 0;
        repeat (150) begin
            @(negedge clk);
            pulses_a += int'(done_a);
            pulses_b += int'(done_b);
        end
        n_total += 2;
        if (pulses_a != 0 || pulses_b != 0) begin
            n_bad++; $display("FAIL gap_empty_done: got %0d/%0d pulses want 0", pulses_a, pulses_b);
        end
        if (pen_a !== 1'b0) begin
            n_bad++; $display("FAIL gap_empty_pen: got %b want 0", pen_a);
        end
    endtask

    task automatic test_clear_collision();
        do_clear();
        send(1200, 900);
        send(1200, 900);
        @(negedge clk);
        clr = 1'b1; nc = 1'b1; x = 12'd1200; y = 12'd900;
        @(negedge clk);
        clr = 1'b0; nc = 1'b0;
        model_clear();
        n_total += 3;
        if (ga !== '0 || gb !== '0 || cnt_a !== 7'd0 || cnt_b !== 7'd0) begin
            n_bad++; $display("FAIL clear_grid: got %h/%h cnt %0d/%0d want 0", ga, gb, cnt_a, cnt_b);
        end
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || pen_a !== 1'b0) begin
            n_bad++; $display("FAIL clear_busy: got %b%b pen %b want 000", busy_a, busy_b, pen_a);
        end
        repeat (20) @(negedge clk);
        if (ga !== '0 || cnt_a !== 7'd0) begin
            n_bad++; $display("FAIL clear_discard: got %h cnt %0d want 0", ga, cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit seen;
        do_clear();
        @(negedge clk);
        x = 12'd1200; y = 12'd900; nc = 1'b1;
        @(negedge clk);
        nc = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy_a !== 1'b1) begin
            n_bad++; $display("FAIL b2b_busy: got %b want 1", busy_a);
        end
        x = 12'd200; y = 12'd200; nc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nc = 1'b0;
        model_sample(1200, 900);
        n = 0; seen = 1'b0;
        while (!seen && n < 3 * GAP) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = done_a;
        end
        n_total += 3;
        if (!seen || n < GAP - 1 || n > GAP + 1) begin
            n_bad++; $display("FAIL b2b_deadline: got done at %0d (seen %b) want %0d", n, seen, GAP);
        end
        @(negedge clk);
        if (done_a !== 1'b0) begin
            n_bad++; $display("FAIL b2b_pulse_width: got %b want 0", done_a);
        end
        model_end_stroke();
        if (ga !== mg[0] || gb !== mg[1]) begin
            n_bad++; $display("FAIL b2b_grid: got %h/%h want %h/%h", ga, gb, mg[0], mg[1]);
        end
    endtask

    task automatic test_random();
        int sx, sy, px, py;
        do_clear();
        px = 1200; py = 900;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 99) < 40) begin
                sx = px; sy = py;
            end else if ($urandom_range(0, 99) < 80) begin
                sx = XMIN + int'($urandom_range(0, 7)) * CW + int'($urandom_range(0, CW - 1));
                sy = YMIN + int'($urandom_range(0, 11)) * CH + int'($urandom_range(0, CH - 1));
            end else begin
                sx = int'($urandom_range(0, 4095));
                sy = int'($urandom_range(0, 4095));
            end
            px = sx; py = sy;
            send(sx, sy);
            n_total += 2;
            if (ga !== mg[0] || cnt_a !== 7'(m_cnt[0])) begin
                n_bad++;
                $display("FAIL rand_a[%0d] (%0d,%0d): got %h cnt %0d want %h cnt %0d",
                         i, sx, sy, ga, cnt_a, mg[0], m_cnt[0]);
            end
            if (gb !== mg[1] || cnt_b !== 7'(m_cnt[1])) begin
                n_bad++;
                $display("FAIL rand_b[%0d] (%0d,%0d): got %h cnt %0d want %h cnt %0d",
                         i, sx, sy, gb, cnt_b, mg[1], m_cnt[1]);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_hit();
        test_hits();
        test_out_of_range();
        test_gap();
        test_clear_collision();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
